ddr4_iod_dly_ctrl: RTL
======================

DDR4_IOD_DLY_CTRL -- requirements
Module: ddr4_iod_dly_ctrl

Interface
REQ-001 The block SHALL have parameter MOVE_GAP, default 4, giving the idle cycles after each DELAY_LINE_MOVE pulse (range 1..15).
REQ-002 The block SHALL have parameter LOAD_VAL, default 8'd1, giving the tap value the delay line takes on a LOAD.
REQ-003 The block SHALL have parameter MAX_TAP, default 8'd255, giving the highest legal tap position.
REQ-004 FAB_CLK  in  1  single fabric clock; all logic is rising-edge.
REQ-005 ARST_N  in  1  reset, asynchronous and active-low.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  high only in IDLE.
REQ-008 cmd_op  in  2  00 LOAD, 01 MOVE_UP, 10 MOVE_DOWN, 11 illegal.
REQ-009 cmd_taps  in  8  tap count for MOVE commands; ignored for LOAD.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 status  out  2  00 OK, 01 OOR, 10 ILLEGAL; valid with done and held until the next done.
REQ-012 tap_pos  out  8  tracked delay-line tap position.
REQ-013 DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD  out  1 each  IOD delay-line controls; DIRECTION 1 means increase delay.
REQ-014 DELAY_LINE_OUT_OF_RANGE  in  1  IOD range flag.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, SETUP, MOVE, GAP and DONE.
REQ-016 A command SHALL be accepted on a cycle where cmd_valid and cmd_ready are both high; cmd_op and cmd_taps are captured on that edge.
REQ-017 LOAD accepted at cycle t: DELAY_LINE_LOAD is high for exactly cycle t+1, tap_pos becomes LOAD_VAL, done pulses at t+2 with status OK.
REQ-018 MOVE accepted at t: SETUP drives DIRECTION at t+1; the first one-cycle MOVE pulse is at t+2; each later tap follows after MOVE_GAP GAP cycles.
REQ-019 A MOVE of N taps SHALL pulse done at t+2+N*(1+MOVE_GAP).
REQ-020 DIRECTION SHALL be stable from SETUP through the final GAP, and SHALL hold its last value in IDLE.
REQ-021 tap_pos SHALL change by +/-1 in the cycle after each MOVE pulse.
REQ-022 A MOVE with cmd_taps=0 SHALL go SETUP->DONE with no MOVE pulse, so done is at t+2 with status OK.
REQ-023 DELAY_LINE_OUT_OF_RANGE SHALL be sampled on the last GAP cycle.
REQ-024 If DELAY_LINE_OUT_OF_RANGE is high when sampled, the block SHALL undo the last tap_pos step, abort the remaining taps, go to DONE and report status OOR.
REQ-025 cmd_op=11 SHALL go directly to DONE (done at t+2), report status ILLEGAL, and leave all delay-line outputs untouched.
REQ-026 cmd_valid outside IDLE SHALL be ignored; it is not queued.
REQ-027 At most one of MOVE and LOAD SHALL be high in any cycle.

Reset
REQ-028 ARST_N low SHALL immediately put the FSM in IDLE.
REQ-029 During reset, MOVE, LOAD, DIRECTION, done and cmd_ready SHALL be 0, status SHALL be 00, and tap_pos SHALL be LOAD_VAL.
REQ-030 cmd_ready SHALL rise on the first clock after reset deassertion.
REQ-031 A reset in the middle of a command SHALL drop any MOVE or LOAD pulse at once and discard the command without producing done.

Configuration
REQ-032 Macro DDR4_IOD_DLY_SOFT_LIMIT_EN defined: before each MOVE pulse, if tap_pos=MAX_TAP going up or 0 going down, the block SHALL skip the pulse, go to DONE and report OOR.
REQ-033 Macro DDR4_IOD_DLY_SOFT_LIMIT_EN undefined: that check SHALL be absent, and only the IOD flag ends a move early; tap_pos wraps modulo 256.

Structure
REQ-034 Package ddr4_iod_dly_pkg SHALL hold the cmd_op encodings, the status encodings and the FSM state enum.
REQ-035 Sub-module ddr4_iod_dly_gap_cnt SHALL implement the MOVE_GAP down-counter with load, and report zero-reached.
REQ-036 Everything else SHALL be in the top module.

Verification
REQ-037 LOAD after reset -> LOAD pulse at t+1, done at t+2, tap_pos=1, status 00.
REQ-038 MOVE_UP with 3 taps, MOVE_GAP=4 -> three MOVE pulses 5 cycles apart at t+2, t+7 and t+12; DIRECTION=1; done at t+17; tap_pos=4.
REQ-039 MOVE_DOWN with 5 taps, OOR forced high during the second GAP -> exactly 2 pulses, then done with status 01, tap_pos=LOAD_VAL-1.
REQ-040 With the macro on, tap_pos=1 and MOVE_DOWN with 3 taps -> 1 pulse, then done with status 01, tap_pos=0, no further pulse.
REQ-041 cmd_op=11, and separately MOVE with 0 taps -> done at t+2, statuses 10 and 00 respectively, no MOVE or LOAD activity.
REQ-042 ARST_N asserted in the middle of a MOVE -> MOVE drops in the same cycle, no done, tap_pos=LOAD_VAL, cmd_ready=1 one cycle after release.

Source files
------------

// File: rtl/ddr4_iod_dly_pkg.sv
// Shared encodings for the DDR4 IOD delay-line controller: command ops, status codes, FSM states.
// Optional soft tap limit is enabled in the top by defining DDR4_IOD_DLY_SOFT_LIMIT_EN.
package ddr4_iod_dly_pkg;

  localparam logic [1:0] OP_LOAD      = 2'b00;
  localparam logic [1:0] OP_MOVE_UP   = 2'b01;
  localparam logic [1:0] OP_MOVE_DOWN = 2'b10;
  localparam logic [1:0] OP_ILLEGAL   = 2'b11;

  localparam logic [1:0] STS_OK       = 2'b00;
  localparam logic [1:0] STS_OOR      = 2'b01;
  localparam logic [1:0] STS_ILLEGAL  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETUP,
    S_MOVE,
    S_GAP,
    S_DONE
  } state_t;

  // One tap step; wraps modulo 256 like the IOD tap counter.
  function automatic logic [7:0] tap_step(input logic [7:0] pos, input logic up);
    return up ? pos + 8'd1 : pos - 8'd1;
  endfunction

endpackage

// File: rtl/ddr4_iod_dly_gap_cnt.sv
// Idle-gap down-counter between delay-line MOVE pulses; loads MOVE_GAP-1 so that
// zero is high on the last of MOVE_GAP gap cycles.
module ddr4_iod_dly_gap_cnt #(
  parameter int unsigned MOVE_GAP = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic zero
);

  logic [3:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (load) begin
      count <= 4'(MOVE_GAP - 1);
    end else if (en && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/ddr4_iod_dly_ctrl.sv
// DDR4 IOD delay-line controller: sequences LOAD and paced MOVE pulses and tracks tap position.
// Define DDR4_IOD_DLY_SOFT_LIMIT_EN to stop a move at tap 0 / MAX_TAP instead of wrapping.
module ddr4_iod_dly_ctrl
  import ddr4_iod_dly_pkg::*;
#(
  parameter int unsigned MOVE_GAP = 4,
  parameter logic [7:0]  LOAD_VAL = 8'd1,
  parameter logic [7:0]  MAX_TAP  = 8'd255
) (
  input  logic       FAB_CLK,
  input  logic       ARST_N,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_taps,
  output logic       done,
  output logic [1:0] status,
  output logic [7:0] tap_pos,
  output logic       DELAY_LINE_MOVE,
  output logic       DELAY_LINE_DIRECTION,
  output logic       DELAY_LINE_LOAD,
  input  logic       DELAY_LINE_OUT_OF_RANGE
);

  state_t     state;
  logic [1:0] op_q;
  logic [7:0] taps_left;
  logic       accept;
  logic       gap_zero;
  logic       at_limit;

  assign accept = (state == S_IDLE) && cmd_valid && cmd_ready;

`ifdef DDR4_IOD_DLY_SOFT_LIMIT_EN
  assign at_limit = DELAY_LINE_DIRECTION ? (tap_pos == MAX_TAP) : (tap_pos == 8'd0);
`else
  logic unused_max_tap;
  assign at_limit       = 1'b0;
  assign unused_max_tap = ^MAX_TAP;
`endif

  ddr4_iod_dly_gap_cnt #(
    .MOVE_GAP (MOVE_GAP)
  ) u_gap_cnt (
    .clk   (FAB_CLK),
    .rst_n (ARST_N),
    .load  (state == S_MOVE),
    .en    (state == S_GAP),
    .zero  (gap_zero)
  );

  // Command payload: captured on accept, tap budget consumed once per MOVE pulse.
  always_ff @(posedge FAB_CLK) begin
    if (accept) begin
      op_q      <= cmd_op;
      taps_left <= cmd_taps;
    end else if (state == S_MOVE) begin
      taps_left <= taps_left - 8'd1;
    end
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state                <= S_IDLE;
      cmd_ready            <= 1'b0;
      done                 <= 1'b0;
      status               <= STS_OK;
      tap_pos              <= LOAD_VAL;
      DELAY_LINE_MOVE      <= 1'b0;
      DELAY_LINE_LOAD      <= 1'b0;
      DELAY_LINE_DIRECTION <= 1'b0;
    end else begin
      DELAY_LINE_MOVE <= 1'b0;
      DELAY_LINE_LOAD <= 1'b0;
      done            <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            cmd_ready <= 1'b0;
            case (cmd_op)
              OP_LOAD: begin
                DELAY_LINE_LOAD <= 1'b1;
                state           <= S_LOAD;
              end
              OP_MOVE_UP: begin
                DELAY_LINE_DIRECTION <= 1'b1;
                state                <= S_SETUP;
              end
              OP_MOVE_DOWN: begin
                DELAY_LINE_DIRECTION <= 1'b0;
                state                <= S_SETUP;
              end
              // Illegal op spends its decode cycle in SETUP so it completes at t+2
              // like the other short commands; direction is left as it was.
              default: state <= S_SETUP;
            endcase
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          tap_pos <= LOAD_VAL;
          done    <= 1'b1;
          status  <= STS_OK;
          state   <= S_DONE;
        end
        S_SETUP: begin
          if (op_q == OP_ILLEGAL) begin
            done   <= 1'b1;
            status <= STS_ILLEGAL;
            state  <= S_DONE;
          end else if (taps_left == 8'd0) begin
            done   <= 1'b1;
            status <= STS_OK;
            state  <= S_DONE;
          end else if (at_limit) begin
            done   <= 1'b1;
            status <= STS_OOR;
            state  <= S_DONE;
          end else begin
            DELAY_LINE_MOVE <= 1'b1;
            state           <= S_MOVE;
          end
        end
        S_MOVE: begin
          tap_pos <= tap_step(tap_pos, DELAY_LINE_DIRECTION);
          state   <= S_GAP;
        end
        S_GAP: begin
          if (gap_zero) begin
            if (DELAY_LINE_OUT_OF_RANGE) begin
              // The IOD refused the last step: take it back and abort.
              tap_pos <= tap_step(tap_pos, ~DELAY_LINE_DIRECTION);
              done    <= 1'b1;
              status  <= STS_OOR;
              state   <= S_DONE;
            end else if (taps_left == 8'd0) begin
              done   <= 1'b1;
              status <= STS_OK;
              state  <= S_DONE;
            end else if (at_limit) begin
              done   <= 1'b1;
              status <= STS_OOR;
              state  <= S_DONE;
            end else begin
              DELAY_LINE_MOVE <= 1'b1;
              state           <= S_MOVE;
            end
          end
        end
        S_DONE: begin
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          cmd_ready <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
